// File: rtl/fir_coef_loader.sv
// Shadow coefficient file plus serial loader for the FIR coefficient shift chain.
// Image is clocked out highest index first so shadow[k] settles in filter tap k.
module fir_coef_loader #(
  parameter int NUM_TAPS = 21,
  parameter int COEF_W   = 16,
  parameter int HALF     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [4:0]        rd_addr,
  output logic [COEF_W-1:0] rd_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              wr_drop,
  output logic [COEF_W-1:0] coef_out,
  output logic              coef_clk
);

  localparam int              CW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [5:0]      NT       = 6'(NUM_TAPS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(HALF - 1);
  localparam logic [4:0]      IDX_TOP  = 5'(NUM_TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  logic [COEF_W-1:0] r_shadow [NUM_TAPS];
  logic [COEF_W-1:0] r_rd_data;
  logic [COEF_W-1:0] r_coef_out;
  logic              r_coef_clk;
  logic              r_busy;
  logic              r_done;
  logic              r_wr_drop;
  logic [4:0]        r_idx;
  logic [CW-1:0]     r_cnt;
  state_t            r_state;

  logic w_wr_ok;
  logic w_rd_ok;

  // Host writes are only safe while the image is not being shifted out.
  assign w_wr_ok = wr_en & ~r_busy & ~start & ({1'b0, wr_addr} < NT);
  assign w_rd_ok = ({1'b0, rd_addr} < NT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) r_shadow[i] <= '0;
    end else if (w_wr_ok) begin
      r_shadow[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_rd_data <= w_rd_ok ? r_shadow[rd_addr] : '0;
      r_wr_drop <= wr_en & (r_busy | start);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_coef_clk <= 1'b0;
      r_coef_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOW;
            r_idx      <= IDX_TOP;
            r_coef_out <= r_shadow[IDX_TOP];
            r_busy     <= 1'b1;
            r_cnt      <= '0;
          end
        end
        S_LOW: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt      <= '0;
            r_coef_clk <= 1'b1;
            r_state    <= S_HIGH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt      <= '0;
            r_coef_clk <= 1'b0;
            // Data only moves on the falling edge, centred between rising edges.
            if (r_idx != 5'd0) begin
              r_idx      <= r_idx - 5'd1;
              r_coef_out <= r_shadow[r_idx - 5'd1];
              r_state    <= S_LOW;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign wr_drop  = r_wr_drop;
  assign coef_out = r_coef_out;
  assign coef_clk = r_coef_clk;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: HALF=2 and HALF=1 instances share all inputs.
module tb_fir_coef_loader;

  localparam int N = 21;

  logic        clk, reset, wr_en, start;
  logic [4:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data, coef_out, rd_data1, coef_out1;
  logic        busy, done, wr_drop, coef_clk;
  logic        busy1, done1, wr_drop1, coef_clk1;

  fir_coef_loader #(.NUM_TAPS(N), .COEF_W(16), .HALF(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .busy(busy), .done(done),
    .wr_drop(wr_drop), .coef_out(coef_out), .coef_clk(coef_clk));

  fir_coef_loader #(.NUM_TAPS(N), .COEF_W(16), .HALF(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1), .start(start), .busy(busy1), .done(done1),
    .wr_drop(wr_drop1), .coef_out(coef_out1), .coef_clk(coef_clk1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  logic [15:0] m_sh [32];

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    logic        exp_drop;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called at a negedge, returns at the next negedge.
  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    if (a < N) m_sh[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic readback_all(input string nm);
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      @(negedge clk);
      chk(nm, rd_data, m_sh[a]);
    end
  endtask

  // mode 0: plain load; 1: busy write + second start; 2: reset at 10th rise; 3: start with write
  task automatic run_load(input int mode);
    logic [15:0] snap [N];
    logic [15:0] filt [N];
    logic [15:0] filt1 [N];
    int rises = 0, rises1 = 0, k = 0;
    logic prev = 1'b0, prev1 = 1'b0, got = 1'b0, got1 = 1'b0;
    for (int i = 0; i < N; i++) begin
      snap[i] = m_sh[i]; filt[i] = 16'hFFFF; filt1[i] = 16'hFFFF;
    end
    start = 1'b1;
    if (mode == 3) begin
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h5A5A;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    chk("e0_busy", busy, 1);
    chk("e0_coef_out", coef_out, snap[N-1]);
    chk("e0_coef_clk", coef_clk, 0);
    if (mode == 3) chk("start_write_drop", wr_drop, 1);
    while (k < 1000) begin
      if (coef_clk1 && !prev1) begin
        chk("h1_rise_time", k, 1 + 2 * rises1);
        if (rises1 < N) chk("h1_rise_data", coef_out1, snap[N-1-rises1]);
        for (int i = N - 1; i > 0; i--) filt1[i] = filt1[i-1];
        filt1[0] = coef_out1;
        rises1++;
      end
      prev1 = coef_clk1;
      if (done1 && !got1) begin
        got1 = 1'b1;
        chk("h1_done_time", k, 2 * N);
      end
      if (coef_clk && !prev) begin
        chk("rise_time", k, 2 + 4 * rises);
        if (rises < N) chk("rise_data", coef_out, snap[N-1-rises]);
        for (int i = N - 1; i > 0; i--) filt[i] = filt[i-1];
        filt[0] = coef_out;
        rises++;
        if (mode == 2 && rises == 10) begin
          reset = 1'b1;
          #1;
          chk("rst_coef_clk", coef_clk, 0);
          chk("rst_busy", busy, 0);
          chk("rst_coef_out", coef_out, 0);
          chk("rst_rd_data", rd_data, 0);
          chk("rst_done", done, 0);
          @(negedge clk);
          reset = 1'b0;
          for (int i = 0; i < 32; i++) m_sh[i] = '0;
          @(negedge clk);
          chk("rst_no_rise", coef_clk, 0);
          return;
        end
      end
      prev = coef_clk;
      if (done) begin
        got = 1'b1;
        chk("done_time", k, 4 * N);
        chk("done_busy", busy, 0);
        break;
      end
      if (mode == 1) begin
        if (k == 20) start = 1'b1;
        if (k == 21) start = 1'b0;
        if (k == 30) begin
          wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'hAAAA;
        end
        if (k == 31) begin
          wr_en = 1'b0;
          chk("busy_wr_drop", wr_drop, 1);
        end
        if (k == 40) rd_addr = 5'd3;
        if (k == 41) chk("busy_readback", rd_data, snap[3]);
      end
      @(negedge clk);
      k++;
    end
    chk("load_done_seen", got, 1);
    chk("rise_count", rises, N);
    chk("h1_rise_count", rises1, N);
    for (int i = 0; i < N; i++) begin
      chk("filter_tap", filt[i], snap[i]);
      chk("h1_filter_tap", filt1[i], snap[i]);
    end
    @(negedge clk);
    chk("idle_hold", coef_out, snap[0]);
    chk("idle_drop", wr_drop, 0);
  endtask

  initial begin
    vec_t tv [5];
    tv[0] = '{5'd5,  16'hBEEF, 16'hBEEF, 1'b0};
    tv[1] = '{5'd25, 16'h1234, 16'h0000, 1'b0};
    tv[2] = '{5'd0,  16'h0F0F, 16'h0F0F, 1'b0};
    tv[3] = '{5'd20, 16'hC001, 16'hC001, 1'b0};
    tv[4] = '{5'd31, 16'hFFFF, 16'h0000, 1'b0};

    for (int i = 0; i < 32; i++) m_sh[i] = '0;
    reset = 1'b1; wr_en = 1'b0; start = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_drop0", wr_drop, 0);
    chk("rst_cclk0", coef_clk, 0);
    chk("rst_cout0", coef_out, 0);
    chk("rst_rd0", rd_data, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < N; i++) wr(5'(i), 16'h0100 + 16'(i));
    run_load(0);

    for (int i = 0; i < 5; i++) begin
      wr(tv[i].addr, tv[i].data);
      chk("tbl_drop", wr_drop, tv[i].exp_drop);
      rd_addr = tv[i].addr;
      @(negedge clk);
      chk("tbl_rd", rd_data, tv[i].exp_rd);
    end

    run_load(1);
    rd_addr = 5'd3;
    @(negedge clk);
    chk("busy_wr_ignored", rd_data, m_sh[3]);
    run_load(3);
    readback_all("start_wr_shadow");

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 40; i++) wr(5'($urandom_range(0, 31)), 16'($urandom));
      readback_all("rand_rd");
      run_load(0);
    end

    run_load(2);
    readback_all("post_rst_rd");
    run_load(0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
